// File: rtl/sa_ctrl.sv
// Sequencer for one NxN output-stationary matrix multiply on the SA systolic array.
// Clears the array, feeds K skewed operand beats, drains the pipeline, then
// latches the accumulators into a held result bank.
module sa_ctrl #(
  parameter int WIDTH = 8,
  parameter int ACC   = 32,
  parameter int N     = 2,
  parameter int KW    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [KW-1:0]                   k_len,
  output logic                            busy,
  input  logic                            op_valid,
  output logic                            op_ready,
  input  logic [N-1:0][WIDTH-1:0]         op_a,
  input  logic [N-1:0][WIDTH-1:0]         op_b,
  output logic                            sa_en,
  output logic                            sa_rst_n,
  output logic [N-1:0][WIDTH-1:0]         sa_a,
  output logic [N-1:0][WIDTH-1:0]         sa_b,
  input  logic [N-1:0][N-1:0][ACC-1:0]    sa_acc,
  output logic [N-1:0][N-1:0][ACC-1:0]    res,
  output logic                            done,
  output logic                            res_valid
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Drain runs 2N-1 advancing cycles so the last product reaches PE(N-1,N-1).
  localparam int              DW         = $clog2(2 * N);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(2 * N - 2);

  logic [2:0]                         state_q, state_d;
  logic [KW-1:0]                      k_q, beat_q;
  logic [DW-1:0]                      drain_q;
  logic                               sa_rst_n_q, res_valid_q;
  logic [N-1:0][N-1:0][ACC-1:0]       res_q;

  logic in_clear, in_feed, in_drain, accept, beat, last_beat, finish_drain;

  assign in_clear     = (state_q == ST_CLEAR);
  assign in_feed      = (state_q == ST_FEED);
  assign in_drain     = (state_q == ST_DRAIN);
  assign accept       = (state_q == ST_IDLE) && start && (k_len != '0);
  assign beat         = in_feed && op_valid;
  assign last_beat    = beat && (beat_q == k_q - KW'(1));
  assign finish_drain = in_drain && (drain_q == DRAIN_LAST);

  assign busy      = (state_q != ST_IDLE);
  assign op_ready  = in_feed;
  assign sa_en     = beat | in_drain;
  assign done      = (state_q == ST_DONE);
  assign sa_rst_n  = sa_rst_n_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED:  if (last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (finish_drain) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters, array reset pulse and result bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      sa_rst_n_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q    <= state_d;
      // Registered so the array sees a clean low for exactly the CLEAR cycle.
      sa_rst_n_q <= (state_d != ST_CLEAR);
      if (accept) begin
        k_q         <= k_len;
        res_valid_q <= 1'b0;
      end
      if (in_clear) beat_q <= '0;
      else if (beat) beat_q <= beat_q + KW'(1);
      if (in_drain) drain_q <= drain_q + DW'(1);
      else drain_q <= '0;
      // The final drain cycle only adds zero products, so sampling here makes
      // res stable for the whole done cycle.
      if (finish_drain) begin
        res_q       <= sa_acc;
        res_valid_q <= 1'b1;
      end
    end
  end

  assign sa_a[0] = in_feed ? op_a[0] : '0;
  assign sa_b[0] = in_feed ? op_b[0] : '0;

  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [WIDTH-1:0] a_ch [i];
    logic [WIDTH-1:0] b_ch [i];
    logic [WIDTH-1:0] a_in, b_in;

    // Zeros enter the chains while draining.
    assign a_in = in_feed ? op_a[i] : '0;
    assign b_in = in_feed ? op_b[i] : '0;

    // i-deep skew chain that only advances when the array advances
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < i; d++) begin
          a_ch[d] <= '0;
          b_ch[d] <= '0;
        end
      end else if (in_clear) begin
        for (int d = 0; d < i; d++) begin
          a_ch[d] <= '0;
          b_ch[d] <= '0;
        end
      end else if (sa_en) begin
        a_ch[0] <= a_in;
        b_ch[0] <= b_in;
        for (int d = 1; d < i; d++) begin
          a_ch[d] <= a_ch[d-1];
          b_ch[d] <= b_ch[d-1];
        end
      end
    end

    assign sa_a[i] = (in_feed | in_drain) ? a_ch[i-1] : '0;
    assign sa_b[i] = (in_feed | in_drain) ? b_ch[i-1] : '0;
  end

endmodule
